// File: rtl/fork_join_pkg.sv
// Shared state encodings and channel mode constants for the fork/join scheduler.
package fork_join_pkg;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_JOIN
  } top_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT_DEP,
    C_COUNT,
    C_FIRED
  } ch_state_t;

  localparam logic MODE_FORK = 1'b0;
  localparam logic MODE_DEP  = 1'b1;

endpackage

// File: rtl/fj_channel.sv
// One forked channel: waits for fork or dependency, counts its delay down,
// then captures its source value and pulses fire.
module fj_channel
  import fork_join_pkg::*;
#(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          clr,
  input  logic          mode,
  input  logic [CW-1:0] dly,
  input  logic          dep,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] ret,
  output logic          fire,
  output logic          fired
);

  ch_state_t     st;
  logic [CW-1:0] cnt;
  logic          step;

  // The dependency edge counts as the first tick, so a D-cycle wait after
  // fire[i-1] lands exactly D+1 cycles later without a combinational chain.
  assign step  = (st == C_COUNT) || ((st == C_WAIT_DEP) && dep);
  assign fired = (st == C_FIRED);

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= C_IDLE;
      cnt  <= '0;
      ret  <= '0;
      fire <= 1'b0;
    end else begin
      fire <= 1'b0;
      if (go) begin
        st  <= (mode == MODE_DEP) ? C_WAIT_DEP : C_COUNT;
        cnt <= dly;
      end else if (clr) begin
        st <= C_IDLE;
      end else if (step) begin
        if (cnt == '0) begin
          fire <= 1'b1;
          ret  <= din;
          st   <= C_FIRED;
        end else begin
          cnt <= cnt - 1'b1;
          st  <= C_COUNT;
        end
      end
    end
  end

endmodule

// File: rtl/fork_join_sched.sv
// Fork/join scheduler: forks NCH delayed channels on start and pulses done
// once every channel has fired.
module fork_join_sched
  import fork_join_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DW  = 4,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NCH-1:0]    mode,
  input  logic [NCH*CW-1:0] delay,
  input  logic [NCH*DW-1:0] data_in,
  output logic [NCH*DW-1:0] ret,
  output logic [NCH-1:0]    fire,
  output logic              busy,
  output logic              done,
  output logic              dropped
);

  top_state_t     st;
  logic           go;
  logic           clr;
  logic [NCH-1:0] fired;
  logic [NCH-1:0] dep;
  logic [NCH-1:0] eff_mode;

  assign go  = (st == T_IDLE) && start;
  assign clr = (st == T_JOIN);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    if (i == 0) begin : g_first
      assign dep[i]      = 1'b0;
      assign eff_mode[i] = MODE_FORK;
    end else begin : g_rest
      assign dep[i]      = fire[i-1];
      assign eff_mode[i] = mode[i];
    end

    fj_channel #(
      .DW(DW),
      .CW(CW)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .go    (go),
      .clr   (clr),
      .mode  (eff_mode[i]),
      .dly   (delay[i*CW +: CW]),
      .dep   (dep[i]),
      .din   (data_in[i*DW +: DW]),
      .ret   (ret[i*DW +: DW]),
      .fire  (fire[i]),
      .fired (fired[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= T_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (st != T_IDLE))
        dropped <= 1'b1;
      case (st)
        T_IDLE: begin
          if (start) begin
            st   <= T_RUN;
            busy <= 1'b1;
          end
        end
        T_RUN: begin
          if (&fired) begin
            st   <= T_JOIN;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: st <= T_IDLE;
      endcase
    end
  end

endmodule
